// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk_if.sv
// Beat/frame bus between the 3-input parity datapath and the frame parity checker.
// Master drives beats and clear; slave returns registered verdicts and error count.
interface gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk_if #(
  parameter int CW = 4
);
  logic          A1;
  logic          A2;
  logic          A3;
  logic          V;
  logic          L;
  logic          P;
  logic          CLR;
  logic          ACC;
  logic          DONE;
  logic          ERR;
  logic          OVFL;
  logic [CW-1:0] ECNT;

  modport master (
    output A1, A2, A3, V, L, P, CLR,
    input  ACC, DONE, ERR, OVFL, ECNT
  );

  modport slave (
    input  A1, A2, A3, V, L, P, CLR,
    output ACC, DONE, ERR, OVFL, ECNT
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk.sv
// Framed parity checker: accumulates A1^A2^A3 per beat and judges each frame against P.
// Verdict pulses one cycle after the accepting edge; always accepts, no backpressure.
module gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk #(
  parameter int CW   = 4,
  parameter int MAXW = 16
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk_if.slave bus
);
  localparam int WW = $clog2(MAXW + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [CW-1:0] ECNT_MAX = '1;
  localparam logic [WW-1:0] LAST_OK  = WW'(MAXW - 1);

  // Supply pins are only present for netlist compatibility.
  wire unused_pwr = VDD ^ VSS;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          acc_q, acc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ovfl_q, ovfl_d;
  logic [CW-1:0] ecnt_q;
  logic          beat;

  assign beat = bus.A1 ^ bus.A2 ^ bus.A3;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovfl_d  = 1'b0;
    if (bus.V) begin
      case (state_q)
        S_IDLE: begin
          if (bus.L) begin
            done_d = 1'b1;
            err_d  = beat ^ bus.P;
          end else begin
            acc_d   = beat;
            wcnt_d  = WW'(1);
            state_d = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (bus.L) begin
            done_d  = 1'b1;
            err_d   = acc_q ^ beat ^ bus.P;
            acc_d   = 1'b0;
            wcnt_d  = '0;
            state_d = S_IDLE;
          end else if (wcnt_q == LAST_OK) begin
            // MAXW-th beat without L: frame is too long, drop the rest of it.
            ovfl_d  = 1'b1;
            err_d   = 1'b1;
            acc_d   = 1'b0;
            wcnt_d  = '0;
            state_d = S_DISCARD;
          end else begin
            acc_d  = acc_q ^ beat;
            wcnt_d = wcnt_q + WW'(1);
          end
        end
        S_DISCARD: begin
          if (bus.L) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = 1'b0;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovfl_q  <= ovfl_d;
      // Clear wins over a coincident increment.
      if (bus.CLR)
        ecnt_q <= '0;
      else if (err_d && ecnt_q != ECNT_MAX)
        ecnt_q <= ecnt_q + CW'(1);
    end
  end

  assign bus.ACC  = acc_q;
  assign bus.DONE = done_q;
  assign bus.ERR  = err_q;
  assign bus.OVFL = ovfl_q;
  assign bus.ECNT = ecnt_q;
endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk.md
# gf180mcu_fd_sc_mcu7t5v0__xnor3_parchk

Framed parity checker that consumes 3-bit words per clock, the same three-operand parity the xnor3 cell evaluates, and accumulates them across a frame. At the last beat of a frame it compares the accumulated parity against an expected parity bit. It flags mismatches and over-length frames, and keeps a saturating error count. It sits directly downstream of the 3-input parity datapath, as the sequential stage that turns per-word parity into a per-frame verdict.

## Interface
- CW, 4, width of error counter ECNT; legal range 1..16.
- MAXW, 16, maximum beats per frame including the last beat; legal range ≥2.
- CLK  input  1  rising-edge clock; the only clock.
- RN  input  1  asynchronous active-low reset.
- VDD  inout  1  power.
- VSS  inout  1  ground.
- A1, A2, A3  input  1 each  data bits of the current beat.
- V  input  1  beat valid; the block always accepts, with no backpressure.
- L  input  1  last beat of frame; qualified by V.
- P  input  1  expected frame parity (XOR of all frame bits); sampled only on V&L.
- CLR  input  1  synchronous clear of ECNT.
- ACC  output  1  running parity of the current frame (registered).
- DONE  output  1  one-cycle pulse: frame completed.
- ERR  output  1  one-cycle pulse: parity mismatch or overflow.
- OVFL  output  1  one-cycle pulse: frame exceeded MAXW beats.
- ECNT  output  CW  saturating error count.

## Operation
- Beat parity: b = A1^A2^A3, which is the inverse of the xnor3 output.
- Internal beat counter WCNT has width clog2(MAXW+1) and counts beats in the current frame.
- FSM has three states: IDLE, ACTIVE, DISCARD.
- IDLE:
  - V&~L: ACC<=b, WCNT<=1, go to ACTIVE.
  - V&L: single-beat frame. F=b. DONE<=1, ERR<=(F!=P). ACC stays 0. Stay in IDLE.
  - ~V: hold.
- ACTIVE:
  - ~V: hold all state; gaps are allowed anywhere in a frame.
  - V&L: F=ACC^b. DONE<=1, ERR<=(F!=P). ACC<=0, WCNT<=0, go to IDLE.
  - V&~L with WCNT<MAXW-1: ACC<=ACC^b, WCNT<=WCNT+1.
  - V&~L with WCNT==MAXW-1: this is the MAXW-th beat and it is not last. OVFL<=1, ERR<=1. ACC<=0, WCNT<=0, go to DISCARD.
- DISCARD:
  - Beats are ignored and ACC stays 0.
  - V&L: DONE<=1, ERR<=0 (the overflow has already been counted), go to IDLE.
- ECNT increments by 1 on every cycle in which ERR is being set, and saturates at 2^CW-1.
- CLR has priority: CLR forces ECNT<=0 even if an increment coincides with it.
- CLR does not affect the FSM, ACC, or pulse outputs.
- A frame that ends exactly at beat MAXW with L asserted is legal and is not an overflow.

## Timing
- All inputs are sampled on the rising edge of CLK.
- All outputs are registered. DONE/ERR/OVFL assert the cycle after the accepting edge and last exactly one cycle.
- ECNT reflects an error in the same cycle that ERR is high.
- ACC shows the updated parity one cycle after each accepted beat.
- Back-to-back frames: a V beat in the cycle immediately after a V&L beat starts a new frame with no dead cycle.
- Reset (RN low, asynchronous) forces:
  - state=IDLE, WCNT=0, ACC=0, DONE=0, ERR=0, OVFL=0, ECNT=0.
- Deassertion of RN is assumed synchronised externally. The first edge after RN rises may accept a beat.
- Reset mid-frame discards the frame: no DONE, no ERR, and no ECNT change survive it.
- V low makes L, P, and A1..A3 don't-care.

## Test plan
- Reset: hold RN=0 with V=1, L=1 toggling. Required: ACC=0, DONE=ERR=OVFL=0, ECNT=0 throughout.
- Single-beat frames:
  - A=(1,1,0), P=0, V=L=1 → DONE=1, ERR=0, ECNT=0 the next cycle.
  - Then A=(1,0,0), P=0 → DONE=1, ERR=1, ECNT=1.
- Multi-beat frame with gaps: beats (1,0,0), idle, (1,1,1), idle, (0,0,0)+L, P=0.
  - ACC reads 1, then 0, then 0 after each beat.
  - DONE=1, ERR=0.
  - Repeat with P=1 → ERR=1.
- Overflow (MAXW=16): 16 beats with V=1, L=0.
  - Cycle after the 16th beat: OVFL=1, ERR=1, ECNT+1.
  - 5 further beats are ignored; then V&L → DONE=1, ERR=0.
  - Separately, 16 beats with L on the 16th → normal DONE, OVFL=0.
- Saturation and clear (CW=4):
  - 17 mismatching frames → ECNT saturates at 15.
  - CLR=1 on the same cycle as a mismatch completes → ECNT=0 the next cycle, while ERR still pulses.
- Reset mid-frame: 2 beats of an ACTIVE frame, then RN pulse low.
  - No DONE appears; ACC=0.
  - Next single-beat frame A=(0,0,1), P=1 → DONE=1, ERR=0.
